// File: rtl/ar_access_ctrl.sv
// Address-register / memory-access sequencer: round-robin arbitration between
// instruction fetch and operand access, one AR load cycle, then a timed mem handshake.
module ar_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic fetch_req,
    input  logic oper_req,
    input  logic oper_we,
    input  logic mem_ack,
    output logic ar_wen,
    output logic ar_sel,
    output logic mem_req,
    output logic mem_we,
    output logic fetch_done,
    output logic oper_done,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             we_lat;
    logic             last;
    logic             to_flag;
    logic [CNT_W-1:0] wcnt;
    logic             grant;
    logic             grant_oper;
    logic             wait_expired;

    assign grant        = fetch_req | oper_req;
    // On a tie the requester that was not served last wins.
    assign grant_oper   = oper_req & (~fetch_req | ~last);
    assign wait_expired = (wcnt == CNT_W'(TIMEOUT - 1));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = LOAD;
            LOAD:    state_next = ACCESS;
            ACCESS:  if (mem_ack || wait_expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            owner   <= 1'b0;
            we_lat  <= 1'b0;
            last    <= 1'b1;
            to_flag <= 1'b0;
            wcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner   <= grant_oper;
                        we_lat  <= grant_oper & oper_we;
                        to_flag <= 1'b0;
                        wcnt    <= '0;
                    end
                end
                ACCESS: begin
                    // An ack in the final wait cycle wins over the timeout.
                    if (!mem_ack) begin
                        if (wait_expired) begin
                            to_flag <= 1'b1;
                        end else begin
                            wcnt <= wcnt + CNT_W'(1);
                        end
                    end
                end
                DONE:    last <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        ar_wen      = 1'b0;
        ar_sel      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        fetch_done  = 1'b0;
        oper_done   = 1'b0;
        timeout_err = 1'b0;
        busy        = (state != IDLE);
        case (state)
            LOAD: begin
                ar_wen = 1'b1;
                ar_sel = owner;
            end
            ACCESS: begin
                mem_req = 1'b1;
                mem_we  = we_lat;
            end
            DONE: begin
                fetch_done  = ~owner;
                oper_done   = owner;
                timeout_err = to_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ar_access_ctrl.sv
// Scoreboard bench for ar_access_ctrl: a driver predicts each access from the
// arbitration/timeout rules and queues it; a monitor checks every done pulse.
module tb_ar_access_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic Clk       = 1'b0;
    logic Rst       = 1'b0;
    logic fetch_req = 1'b0;
    logic oper_req  = 1'b0;
    logic oper_we   = 1'b0;
    logic mem_ack   = 1'b0;
    logic ar_wen, ar_sel, mem_req, mem_we, fetch_done, oper_done, busy, timeout_err;
    logic [7:0] outs;

    ar_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .fetch_req  (fetch_req),
        .oper_req   (oper_req),
        .oper_we    (oper_we),
        .mem_ack    (mem_ack),
        .ar_wen     (ar_wen),
        .ar_sel     (ar_sel),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .fetch_done (fetch_done),
        .oper_done  (oper_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    assign outs = {ar_wen, ar_sel, mem_req, mem_we, fetch_done, oper_done, busy, timeout_err};

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit oper;
        bit we;
        int len;
        bit to;
        int t_load;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: pending requests and the last-served requester.
    bit fp      = 1'b0;
    bit op      = 1'b0;
    bit m_last  = 1'b1;
    bit in_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic monitor();
        int   t_load = 0;
        int   len = 0;
        logic sel = 1'b0;
        logic we_first = 1'b0;
        logic we_bad = 1'b0;
        exp_t e;
        forever begin
            @(negedge Clk or posedge Rst);
            if (Rst) begin
                len    = 0;
                we_bad = 1'b0;
                continue;
            end
            if (ar_wen) begin
                t_load = cyc;
                sel    = ar_sel;
                len    = 0;
                we_bad = 1'b0;
                check("busy_in_load", busy, 1);
            end
            if (mem_req) begin
                if (len == 0) we_first = mem_we;
                else if (mem_we !== we_first) we_bad = 1'b1;
                len++;
            end
            if (fetch_done || oper_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {fetch_done, oper_done}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", {fetch_done, oper_done}, e.oper ? 2'b01 : 2'b10);
                    check("ar_sel", sel, e.oper);
                    check("load_cycle", t_load, e.t_load);
                    check("access_len", len, e.len);
                    check("mem_we", {we_bad, we_first}, {1'b0, e.we});
                    check("timeout_err", timeout_err, e.to);
                    check("done_cycle", cyc, e.t_load + 1 + e.len);
                end
                len    = 0;
                we_bad = 1'b0;
            end
        end
    endtask

    // d = ACCESS cycle (0-based) in which mem_ack is returned; d >= TIMEOUT means never.
    task automatic do_txn(input bit add_f, input bit add_o, input bit we, input int d,
                          input bit flip_we, input bit drop_req, input int gap);
        exp_t e;
        bit   win_oper;
        int   acc = 0;
        int   guard = 0;
        bit   loaded = 1'b0;
        bit   fin = 1'b0;
        fp = fp | add_f;
        op = op | add_o;
        if (!fp && !op) fp = 1'b1;
        fetch_req = fp;
        oper_req  = op;
        oper_we   = we;
        win_oper  = op && (!fp || !m_last);
        e.oper    = win_oper;
        e.we      = win_oper && we;
        e.to      = (d >= TIMEOUT);
        e.len     = (d >= TIMEOUT) ? TIMEOUT : d + 1;
        e.t_load  = cyc + (in_done ? 2 : 1);
        exp_q.push_back(e);
        while (!fin) begin
            @(negedge Clk);
            guard++;
            if (mem_req) begin
                acc++;
                mem_ack = (acc == d + 1);
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            if (ar_wen && !loaded) begin
                loaded = 1'b1;
                if (flip_we) oper_we = ~oper_we;
                if (drop_req) begin
                    if (win_oper) oper_req = 1'b0;
                    else fetch_req = 1'b0;
                end
            end
            if (fetch_done || oper_done) begin
                fin     = 1'b1;
                mem_ack = 1'b0;
            end else if (guard > 3 * TIMEOUT + 10) begin
                check("txn_guard_expired", guard, 0);
                fin = 1'b1;
            end
        end
        if (win_oper) begin
            op       = 1'b0;
            oper_req = 1'b0;
        end else begin
            fp        = 1'b0;
            fetch_req = 1'b0;
        end
        m_last  = win_oper;
        in_done = 1'b1;
        if (!fp && !op && gap > 0) begin
            repeat (gap) begin
                @(negedge Clk);
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            in_done = 1'b0;
        end
    endtask

    initial begin
        int guard;
        int r;
        int d;
        fork
            monitor();
        join_none

        #1 Rst = 1'b1;
        #1 check("reset_outputs", outs, 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // mem_ack while idle with no requests must be ignored
        mem_ack = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            check("idle_ack_quiet", outs, 0);
        end
        mem_ack = 1'b0;
        in_done = 1'b0;

        do_txn(1, 0, 0, 2, 0, 0, 2);              // single fetch, ack in 3rd ACCESS cycle
        do_txn(0, 1, 1, 0, 1, 0, 2);              // operand write, we flipped after grant
        do_txn(1, 1, 0, 0, 0, 0, 0);              // tie -> fetch
        do_txn(1, 0, 1, 0, 0, 0, 0);              // tie -> oper
        do_txn(0, 1, 1, 0, 0, 0, 0);              // tie -> fetch
        do_txn(1, 0, 0, 0, 0, 0, 0);              // tie -> oper
        do_txn(0, 0, 0, TIMEOUT + 1, 0, 0, 0);    // no ack: timeout
        do_txn(1, 0, 0, TIMEOUT - 1, 0, 0, 2);    // ack in last ACCESS cycle: no error

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) d = $urandom_range(0, 4);
            else if (r < 8) d = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            else d = $urandom_range(0, TIMEOUT + 2);
            do_txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), d,
                   $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end
        while (fp || op) do_txn(0, 0, 0, $urandom_range(0, 3), 0, 0, 1);

        // Reset pulse in the middle of an operand access
        oper_req = 1'b1;
        op       = 1'b1;
        mem_ack  = 1'b0;
        guard    = 0;
        while (!mem_req && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        check("abort_access_reached", mem_req, 1);
        repeat (3) @(negedge Clk);
        fetch_req = 1'b1;
        fp        = 1'b1;
        #1 Rst = 1'b1;
        #1 check("abort_outputs", outs, 0);
        @(negedge Clk);
        check("abort_held", outs, 0);
        Rst     = 1'b0;
        m_last  = 1'b1;
        in_done = 1'b0;
        do_txn(0, 0, 0, 1, 0, 0, 0);              // pending tie after reset -> fetch
        do_txn(0, 0, 0, 0, 0, 0, 2);              // then the held operand request

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ar_access_ctrl.md
Name: ar_access_ctrl

Overview:
- Sequencer for the processor's address register (AR) and its memory access.
- Two requesters share AR and memory: instruction fetch, whose address comes from BusOut, and operand access, whose address comes from IOut.
- Round-robin arbitration between them. For the winner it drives AR WEN/selAR for one load cycle, then runs a mem_req/mem_ack handshake with timeout, and returns a one-cycle done pulse.

Parameters:
- TIMEOUT, 15: maximum cycles in ACCESS without mem_ack before the access is aborted; legal range 1..(2^CNT_W - 1).
- CNT_W, 4: width of the wait counter.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous active-high reset
- fetch_req  input  1  fetch requester wants an access; held until fetch_done
- oper_req  input  1  operand requester wants an access; held until oper_done
- oper_we  input  1  operand access is a write; sampled at grant
- mem_ack  input  1  memory completed the current access
- ar_wen  output  1  AR write enable
- ar_sel  output  1  AR source select: 1 = IOut (operand), 0 = BusOut (fetch)
- mem_req  output  1  memory access request
- mem_we  output  1  memory write strobe, valid while mem_req = 1
- fetch_done  output  1  one-cycle completion pulse to the fetch requester
- oper_done  output  1  one-cycle completion pulse to the operand requester
- busy  output  1  high in every state except IDLE
- timeout_err  output  1  one-cycle pulse, concurrent with the done pulse, when the access timed out

Behaviour:
- All outputs decode from registered state only; there are no combinational paths from inputs to outputs.
- States and encoding: IDLE = 0, LOAD = 1, ACCESS = 2, DONE = 3.
- Internal registers:
  - owner (0 = fetch, 1 = oper)
  - we_lat
  - last (last-served requester)
  - to_flag
  - wcnt[CNT_W-1:0]
- Reset (async, Rst = 1):
  - state = IDLE, owner = 0, we_lat = 0, last = 1, to_flag = 0, wcnt = 0.
  - Every output is 0.
  - Reset asserted mid-access aborts immediately: mem_req and ar_wen drop asynchronously and no done pulse is issued.
- IDLE:
  - No request present: stay in IDLE.
  - Exactly one request present: grant it.
  - Both requests present: grant the requester that is not `last`. After reset fetch therefore wins the first tie.
  - On grant: load owner; load we_lat = oper_we if owner = oper, else 0; clear wcnt and to_flag; next state LOAD.
- LOAD (exactly 1 cycle):
  - ar_wen = 1, ar_sel = owner.
  - AR captures its input on the edge that leaves LOAD.
  - Next state ACCESS.
- ACCESS:
  - mem_req = 1, mem_we = we_lat.
  - mem_ack = 1: next state DONE.
  - Else if wcnt == TIMEOUT-1: set to_flag, next state DONE.
  - Else wcnt increments.
  - mem_ack takes precedence over timeout in the same cycle; no error is reported in that case.
- DONE (exactly 1 cycle):
  - fetch_done = (owner == 0); oper_done = (owner == 1); timeout_err = to_flag.
  - last <= owner; next state IDLE.
- Latency:
  - Request high in IDLE at cycle 0 gives LOAD in cycle 1 and ACCESS from cycle 2.
  - mem_ack in cycle n gives DONE in cycle n+1 and IDLE in cycle n+2.
  - Minimum turnaround is 4 cycles (request at cycle 0, done at cycle 3).
  - Back-to-back grants are separated by one IDLE cycle.
- Requests are only sampled in IDLE.
  - A request that deasserts after grant does not cancel the access; the access completes normally.
  - oper_we changes after grant are ignored.
- mem_ack outside ACCESS is ignored.

Test Plan:
- Reset then single fetch: Rst 1→0, fetch_req = 1 at cycle 0, mem_ack = 1 at cycle 4.
  - Required: ar_wen = 1 and ar_sel = 0 in cycle 1; mem_req = 1 and mem_we = 0 in cycles 2–4; fetch_done = 1 only in cycle 5; busy = 0 from cycle 6.
- Operand write: oper_req = 1, oper_we = 1 at grant, then oper_we dropped to 0 in ACCESS, mem_ack at the first ACCESS cycle.
  - Required: ar_sel = 1 in LOAD; mem_we = 1 throughout ACCESS; oper_done pulse 3 cycles after the request.
- Simultaneous fetch_req and oper_req held continuously, mem_ack returned immediately each time.
  - Required: grant order fetch, oper, fetch, oper; each done pulse goes only to its own requester.
- Timeout with TIMEOUT = 15 and no mem_ack: mem_req stays high for exactly 15 cycles, then the done pulse and timeout_err = 1 assert together.
  - Repeat with mem_ack arriving in the 15th ACCESS cycle: required timeout_err = 0.
- Rst pulsed for 1 cycle in the middle of ACCESS: all outputs go to 0 immediately, no done pulse is issued, and after reset a pending oper/fetch tie is granted to fetch.
- mem_ack held high while IDLE with no requests: required no state change and all outputs remain 0.
